// File: rtl/gerenciador_vitais.sv
// gerenciador_vitais
// Keeps the pet's vitals (saciedade, energia, alegria) and its age, advancing
// them once per prescaled game tick according to the current one-hot pet state.
// Raises a sticky 'morreu' flag as soon as any vital reaches zero; from then on
// the vitals and the age are frozen until reset, while the tick keeps running.

module gerenciador_vitais #(
    parameter int TICK_DIV = 50_000_000,
    parameter int W        = 4,
    parameter int MAX      = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   estado,
    output logic [W-1:0] saciedade,
    output logic [W-1:0] energia,
    output logic [W-1:0] alegria,
    output logic [7:0]   idade,
    output logic         tick,
    output logic         morreu
);

    // Prescaler width; a two-cycle tick still needs one bit.
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0]       PRESC_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]       PRESC_ONE  = CW'(1);
    localparam logic [W-1:0]        VITAL_MAX  = W'(MAX);
    localparam logic signed [W+1:0] MAX_S      = (W+2)'(MAX);

    // Signed deltas, two guard bits above the vital width so that
    // underflow shows up as a negative value instead of wrapping.
    localparam logic signed [W+1:0] D_ZERO   = (W+2)'(0);
    localparam logic signed [W+1:0] D_PLUS2  = (W+2)'(2);
    localparam logic signed [W+1:0] D_MINUS1 = ~((W+2)'(0));
    localparam logic signed [W+1:0] D_MINUS2 = ~((W+2)'(1));

    // One-hot pet state encoding shared with the state controller.
    localparam logic [3:0] ST_IDLE       = 4'b0000;
    localparam logic [3:0] ST_DORMINDO   = 4'b0001;
    localparam logic [3:0] ST_COMENDO    = 4'b0010;
    localparam logic [3:0] ST_DANDO_AULA = 4'b0100;
    localparam logic [3:0] ST_MORTO      = 4'b1000;

    localparam logic [7:0] AGE_LAST = 8'd255;
    localparam logic [7:0] AGE_ONE  = 8'd1;

    // Adds a signed delta to a vital and clamps the result into [0, MAX].
    function automatic logic [W-1:0] clamp_add_f(
        input logic [W-1:0]        cur,
        input logic signed [W+1:0] delta
    );
        logic signed [W+1:0] sum;
        sum = $signed({2'b00, cur}) + delta;
        if (sum[W+1]) begin
            clamp_add_f = {W{1'b0}};
        end else if (sum > MAX_S) begin
            clamp_add_f = VITAL_MAX;
        end else begin
            clamp_add_f = sum[W-1:0];
        end
    endfunction

    logic [CW-1:0] presc_r;
    logic          tick_r;
    logic [W-1:0]  sac_r;
    logic [W-1:0]  ene_r;
    logic [W-1:0]  ale_r;
    logic [7:0]    idade_r;
    logic          morreu_r;

    logic                tick_now_s;
    logic                morto_s;
    logic                update_s;
    logic signed [W+1:0] d_sac_s;
    logic signed [W+1:0] d_ene_s;
    logic signed [W+1:0] d_ale_s;
    logic [W-1:0]        sac_nxt_s;
    logic [W-1:0]        ene_nxt_s;
    logic [W-1:0]        ale_nxt_s;
    logic [7:0]          idade_nxt_s;
    logic                zero_s;

    // Tick strobe: last cycle of each prescaler period.
    always_comb begin
        tick_now_s = (presc_r == PRESC_LAST);
    end

    // Per-state deltas; unknown encodings behave like IDLE, MORTO blocks updates.
    always_comb begin
        d_sac_s = D_MINUS1;
        d_ene_s = D_MINUS1;
        d_ale_s = D_MINUS1;
        morto_s = 1'b0;
        case (estado)
            ST_IDLE: begin
                d_sac_s = D_MINUS1;
                d_ene_s = D_MINUS1;
                d_ale_s = D_MINUS1;
            end
            ST_COMENDO: begin
                d_sac_s = D_PLUS2;
                d_ene_s = D_MINUS1;
                d_ale_s = D_ZERO;
            end
            ST_DORMINDO: begin
                d_sac_s = D_MINUS1;
                d_ene_s = D_PLUS2;
                d_ale_s = D_ZERO;
            end
            ST_DANDO_AULA: begin
                d_sac_s = D_MINUS1;
                d_ene_s = D_MINUS2;
                d_ale_s = D_PLUS2;
            end
            ST_MORTO: begin
                d_sac_s = D_ZERO;
                d_ene_s = D_ZERO;
                d_ale_s = D_ZERO;
                morto_s = 1'b1;
            end
            default: begin
                d_sac_s = D_MINUS1;
                d_ene_s = D_MINUS1;
                d_ale_s = D_MINUS1;
            end
        endcase
    end

    // Candidate next values for a tick edge and the death condition they imply.
    always_comb begin
        sac_nxt_s = clamp_add_f(sac_r, d_sac_s);
        ene_nxt_s = clamp_add_f(ene_r, d_ene_s);
        ale_nxt_s = clamp_add_f(ale_r, d_ale_s);
        if (idade_r == AGE_LAST) begin
            idade_nxt_s = AGE_LAST;
        end else begin
            idade_nxt_s = idade_r + AGE_ONE;
        end
        zero_s   = (sac_nxt_s == {W{1'b0}}) ||
                   (ene_nxt_s == {W{1'b0}}) ||
                   (ale_nxt_s == {W{1'b0}});
        update_s = tick_now_s && !morreu_r && !morto_s;
    end

    // Free-running prescaler; a reset discards any partial period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {CW{1'b0}};
        end else if (tick_now_s) begin
            presc_r <= {CW{1'b0}};
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Registered tick output, one cycle behind the internal strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= tick_now_s;
        end
    end

    // Vitals, age and sticky death flag; only move on a live, non-MORTO tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sac_r    <= VITAL_MAX;
            ene_r    <= VITAL_MAX;
            ale_r    <= VITAL_MAX;
            idade_r  <= 8'd0;
            morreu_r <= 1'b0;
        end else if (update_s) begin
            sac_r    <= sac_nxt_s;
            ene_r    <= ene_nxt_s;
            ale_r    <= ale_nxt_s;
            idade_r  <= idade_nxt_s;
            morreu_r <= zero_s;
        end else begin
            sac_r    <= sac_r;
            ene_r    <= ene_r;
            ale_r    <= ale_r;
            idade_r  <= idade_r;
            morreu_r <= morreu_r;
        end
    end

    assign saciedade = sac_r;
    assign energia   = ene_r;
    assign alegria   = ale_r;
    assign idade     = idade_r;
    assign tick      = tick_r;
    assign morreu    = morreu_r;

endmodule

// File: tb/tb_gerenciador_vitais.sv
// Bench for gerenciador_vitais with TICK_DIV=4, W=4, MAX=15.
// A cycle-level reference model (integer vitals, edge counting since reset
// release) is compared against the DUT on every falling clock edge; directed
// scenarios add literal expectations, then a randomized phase follows.

module tb_gerenciador_vitais;

    localparam int TD  = 4;
    localparam int W   = 4;
    localparam int MAX = 15;

    logic         clk;
    logic         rst_n;
    logic [3:0]   estado;
    logic [W-1:0] saciedade;
    logic [W-1:0] energia;
    logic [W-1:0] alegria;
    logic [7:0]   idade;
    logic         tick;
    logic         morreu;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_sac   = MAX;
    int m_ene   = MAX;
    int m_ale   = MAX;
    int m_age   = 0;
    int m_dead  = 0;
    int m_tick  = 0;
    int n_edges = 0;
    bit cmp_en  = 1'b0;

    gerenciador_vitais #(.TICK_DIV(TD), .W(W), .MAX(MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .estado    (estado),
        .saciedade (saciedade),
        .energia   (energia),
        .alegria   (alegria),
        .idade     (idade),
        .tick      (tick),
        .morreu    (morreu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < 0) return 0;
        if (v > MAX) return MAX;
        return v;
    endfunction

    // Reference model: every TD-th rising edge after release is a game tick.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                m_sac = MAX; m_ene = MAX; m_ale = MAX;
                m_age = 0; m_dead = 0; m_tick = 0; n_edges = 0;
            end else begin
                n_edges++;
                if (n_edges % TD == 0) begin
                    int ds, de, da;
                    m_tick = 1;
                    case (estado)
                        4'b0001: begin ds = -1; de =  2; da = 0;  end
                        4'b0010: begin ds =  2; de = -1; da = 0;  end
                        4'b0100: begin ds = -1; de = -2; da = 2;  end
                        default: begin ds = -1; de = -1; da = -1; end
                    endcase
                    if (m_dead == 0 && estado != 4'b1000) begin
                        m_sac = clampv(m_sac + ds);
                        m_ene = clampv(m_ene + de);
                        m_ale = clampv(m_ale + da);
                        m_age = (m_age < 255) ? m_age + 1 : 255;
                        if (m_sac == 0 || m_ene == 0 || m_ale == 0) m_dead = 1;
                    end
                end else begin
                    m_tick = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("saciedade", 32'(saciedade), m_sac);
            chk("energia",   32'(energia),   m_ene);
            chk("alegria",   32'(alegria),   m_ale);
            chk("idade",     32'(idade),     m_age);
            chk("tick",      32'(tick),      m_tick);
            chk("morreu",    32'(morreu),    m_dead);
        end
    end

    // Pull reset mid-cycle, confirm the asynchronous effect, then release.
    task automatic apply_reset(input logic [3:0] st);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sac",    32'(saciedade), 15);
        chk("rst_ene",    32'(energia),   15);
        chk("rst_ale",    32'(alegria),   15);
        chk("rst_idade",  32'(idade),     0);
        chk("rst_tick",   32'(tick),      0);
        chk("rst_morreu", 32'(morreu),    0);
        @(negedge clk);
        #2;
        estado = st;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
    endtask

    task automatic run_edges(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] pick_state();
        int s;
        s = $urandom_range(0, 6);
        case (s)
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0010;
            3:       return 4'b0100;
            4:       return 4'b1000;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst_n  = 1'b1;
        estado = 4'b0000;

        // 1: reset values and first tick timing
        apply_reset(4'b0000);
        run_edges(3);
        chk("s1_tick_early", 32'(tick), 0);
        chk("s1_sac_early",  32'(saciedade), 15);
        run_edges(1);
        chk("s1_tick_first", 32'(tick), 1);
        chk("s1_sac_first",  32'(saciedade), 14);
        chk("s1_idade",      32'(idade), 1);
        run_edges(1);
        chk("s1_tick_width", 32'(tick), 0);

        // 2: IDLE for 15 ticks, death, then frozen
        apply_reset(4'b0000);
        run_edges(14 * TD);
        chk("s2_sac_14",    32'(saciedade), 1);
        chk("s2_morreu_14", 32'(morreu), 0);
        run_edges(TD);
        chk("s2_sac",    32'(saciedade), 0);
        chk("s2_ene",    32'(energia),   0);
        chk("s2_ale",    32'(alegria),   0);
        chk("s2_idade",  32'(idade),     15);
        chk("s2_morreu", 32'(morreu),    1);
        run_edges(3 * TD);
        chk("s2_frz_idade",  32'(idade),  15);
        chk("s2_frz_morreu", 32'(morreu), 1);
        chk("s2_frz_sac",    32'(saciedade), 0);

        // 3: COMENDO for one tick saturates saciedade
        apply_reset(4'b0010);
        run_edges(TD);
        chk("s3_sac", 32'(saciedade), 15);
        chk("s3_ene", 32'(energia),   14);
        chk("s3_ale", 32'(alegria),   15);

        // 4: DANDO_AULA for 8 ticks, energia clamps at 0
        apply_reset(4'b0100);
        run_edges(7 * TD);
        chk("s4_ene_7",    32'(energia), 1);
        chk("s4_morreu_7", 32'(morreu),  0);
        run_edges(TD);
        chk("s4_ene",    32'(energia),   0);
        chk("s4_sac",    32'(saciedade), 7);
        chk("s4_ale",    32'(alegria),   15);
        chk("s4_idade",  32'(idade),     8);
        chk("s4_morreu", 32'(morreu),    1);

        // 5: MORTO leaves everything untouched
        apply_reset(4'b1000);
        run_edges(5 * TD);
        chk("s5_sac",    32'(saciedade), 15);
        chk("s5_idade",  32'(idade),     0);
        chk("s5_morreu", 32'(morreu),    0);

        // 6: asynchronous reset mid-count with vitals at 9
        apply_reset(4'b0000);
        run_edges(6 * TD + 2);
        chk("s6_sac_before", 32'(saciedade), 9);
        apply_reset(4'b0000);
        run_edges(TD - 1);
        chk("s6_sac_wait",  32'(saciedade), 15);
        chk("s6_tick_wait", 32'(tick), 0);
        run_edges(1);
        chk("s6_sac_tick", 32'(saciedade), 14);
        chk("s6_tick",     32'(tick), 1);

        // randomized phase: state changes at any cycle, occasional mid-count resets
        for (int r = 0; r < 4; r++) begin
            apply_reset(pick_state());
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                #1;
                if ($urandom_range(0, 7) == 0) estado = pick_state();
                if ($urandom_range(0, 149) == 0) begin
                    rst_n = 1'b0;
                    #2 rst_n = 1'b1;
                end
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
